// File: rtl/sprite_param_regs_if.sv
// Avalon-MM slave bus bundle for sprite_param_regs.
// Word-addressed, fixed read latency of 1, no waitrequest.
interface sprite_param_regs_if;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (output avs_address, avs_read, avs_write, avs_writedata,
                  input  avs_readdata);
  modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                  output avs_readdata);
endinterface

// File: rtl/sprite_param_regs.sv
// Double-buffered sprite parameter register file.
// CPU writes land in a shadow set. The whole shadow set is copied to the
// active outputs on a frame_sync rising edge, so a frame never shows a
// half-updated sprite set.
// Optional feature: define SPRITE_PARAMS_READBACK_EN to read shadow
// POS/ATTR words back. Without it, sprite addresses read as 0.
module sprite_param_regs #(
  parameter int NUM_SPRITES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  sprite_param_regs_if.slave        avs,
  input  logic                      frame_sync,
  output logic [NUM_SPRITES*10-1:0] spr_x,
  output logic [NUM_SPRITES*10-1:0] spr_y,
  output logic [NUM_SPRITES*4-1:0]  spr_frame,
  output logic [NUM_SPRITES-1:0]    spr_en,
  output logic                      commit_pulse
);

  localparam logic [7:0] ADDR_CTRL   = 8'h80;
  localparam logic [7:0] ADDR_STATUS = 8'h81;
  localparam logic [7:0] ADDR_FCNT   = 8'h82;

  logic        r_fs_d;
  logic        r_pending;
  logic        r_commit_req;
  logic        r_auto_commit;
  logic [15:0] r_frame_cnt;
  logic        r_commit_pulse;
  logic [31:0] r_readdata;

  logic [6:0]  w_idx;
  logic        w_spr_region;
  logic        w_spr_wr;
  logic        w_ctrl_wr;
  logic        w_edge;
  logic        w_commit;
  logic [31:0] w_rdata;
  logic        w_unused_wdata;

  assign w_idx        = avs.avs_address[7:1];
  assign w_spr_region = ~avs.avs_address[7] && (w_idx < 7'(NUM_SPRITES));
  assign w_spr_wr     = avs.avs_write && w_spr_region;
  assign w_ctrl_wr    = avs.avs_write && (avs.avs_address == ADDR_CTRL);
  assign w_edge       = frame_sync && ~r_fs_d;
  // The commit decision uses register state from before any write in this
  // cycle. A colliding write therefore never changes what is committed.
  assign w_commit     = w_edge && ((r_auto_commit && r_pending) || r_commit_req);

  // These writedata bits sit in reserved fields of the register map.
  assign w_unused_wdata = &{avs.avs_writedata[15:10], avs.avs_writedata[30:26]};

`ifdef SPRITE_PARAMS_READBACK_EN
  logic [NUM_SPRITES-1:0][31:0] w_sh_pos;
  logic [NUM_SPRITES-1:0][31:0] w_sh_attr;
`endif

  genvar k;
  generate
    for (k = 0; k < NUM_SPRITES; k++) begin : g_spr
      logic [9:0] r_sh_x, r_sh_y, r_act_x, r_act_y;
      logic [3:0] r_sh_frame, r_act_frame;
      logic       r_sh_en, r_act_en;
      logic       w_sel;

      assign w_sel = w_spr_wr && (w_idx == 7'(k));

      // Per-sprite shadow and active copies. The active copy only moves on
      // a commit and picks up the shadow value from before this cycle's write.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sh_x <= '0; r_sh_y <= '0; r_sh_frame <= '0; r_sh_en <= 1'b0;
          r_act_x <= '0; r_act_y <= '0; r_act_frame <= '0; r_act_en <= 1'b0;
        end else begin
          if (w_commit) begin
            r_act_x     <= r_sh_x;
            r_act_y     <= r_sh_y;
            r_act_frame <= r_sh_frame;
            r_act_en    <= r_sh_en;
          end
          if (w_sel && !avs.avs_address[0]) begin
            r_sh_x <= avs.avs_writedata[9:0];
            r_sh_y <= avs.avs_writedata[25:16];
          end
          if (w_sel && avs.avs_address[0]) begin
            r_sh_frame <= avs.avs_writedata[3:0];
            r_sh_en    <= avs.avs_writedata[31];
          end
        end
      end

      assign spr_x[10*k +: 10]    = r_act_x;
      assign spr_y[10*k +: 10]    = r_act_y;
      assign spr_frame[4*k +: 4]  = r_act_frame;
      assign spr_en[k]            = r_act_en;
`ifdef SPRITE_PARAMS_READBACK_EN
      assign w_sh_pos[k]  = {6'b0, r_sh_y, 6'b0, r_sh_x};
      assign w_sh_attr[k] = {r_sh_en, 27'b0, r_sh_frame};
`endif
    end
  endgenerate

  // Control state: frame-edge history, pending flag, commit request,
  // auto-commit mode and the free-running frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_d         <= 1'b0;
      r_pending      <= 1'b0;
      r_commit_req   <= 1'b0;
      r_auto_commit  <= 1'b1;
      r_frame_cnt    <= '0;
      r_commit_pulse <= 1'b0;
    end else begin
      r_fs_d         <= frame_sync;
      r_commit_pulse <= w_commit;
      if (w_edge) r_frame_cnt <= r_frame_cnt + 16'd1;
      // A sprite write in the same cycle as a commit leaves fresh data in
      // the shadow set, so pending must stay set.
      if (w_spr_wr)      r_pending <= 1'b1;
      else if (w_commit) r_pending <= 1'b0;
      if (w_ctrl_wr) r_auto_commit <= avs.avs_writedata[0];
      // A commit consumes the request. A request written on a non-committing
      // edge stays set and is serviced on the next edge.
      if (w_commit)                            r_commit_req <= 1'b0;
      else if (w_ctrl_wr && avs.avs_writedata[1]) r_commit_req <= 1'b1;
    end
  end

  // Read mux over register state from before this cycle's write.
  always_comb begin
    w_rdata = '0;
    case (avs.avs_address)
      ADDR_CTRL:   w_rdata = {30'b0, r_commit_req, r_auto_commit};
      ADDR_STATUS: w_rdata = {30'b0, r_commit_req, r_pending};
      ADDR_FCNT:   w_rdata = {16'b0, r_frame_cnt};
      default: begin
`ifdef SPRITE_PARAMS_READBACK_EN
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (w_spr_region && (w_idx == 7'(i)))
            w_rdata = avs.avs_address[0] ? w_sh_attr[i] : w_sh_pos[i];
        end
`endif
      end
    endcase
  end

  // Readdata is registered with a latency of 1 and holds between reads.
  always_ff @(posedge clk) begin
    if (reset)              r_readdata <= '0;
    else if (avs.avs_read)  r_readdata <= w_rdata;
  end

  assign avs.avs_readdata = r_readdata;
  assign commit_pulse     = r_commit_pulse;

endmodule

// File: tb/tb_sprite_param_regs.sv
// Directed bench for sprite_param_regs with NUM_SPRITES = 8.
module tb_sprite_param_regs;
  localparam int NS = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_sync = 1'b0;
  logic [NS*10-1:0] spr_x, spr_y;
  logic [NS*4-1:0]  spr_frame;
  logic [NS-1:0]    spr_en;
  logic             commit_pulse;
  int checks = 0;
  int errors = 0;

  sprite_param_regs_if bus();

  sprite_param_regs #(.NUM_SPRITES(NS)) dut (
    .clk(clk), .reset(reset), .avs(bus), .frame_sync(frame_sync),
    .spr_x(spr_x), .spr_y(spr_y), .spr_frame(spr_frame), .spr_en(spr_en),
    .commit_pulse(commit_pulse)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic frame_edge();
    @(negedge clk); frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (spr_x !== '0) begin errors++; $display("FAIL reset_spr_x got %h exp 0", spr_x); end
    checks++; if (spr_y !== '0) begin errors++; $display("FAIL reset_spr_y got %h exp 0", spr_y); end
    checks++; if ({spr_frame, spr_en} !== '0) begin errors++; $display("FAIL reset_frame_en got %h exp 0", {spr_frame, spr_en}); end
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", commit_pulse); end
    checks++; if (bus.avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.avs_readdata); end
    bus_read(8'h80, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got %h exp 1", d); end
    bus_read(8'h81, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", d); end
    bus_read(8'h82, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_fcnt got %h exp 0", d); end
  endtask

  task automatic test_commit_edge();
    logic [31:0] d;
    bus_write(8'h00, 32'h0064_0032);
    checks++; if (spr_x[9:0] !== 10'h0) begin errors++; $display("FAIL pre_edge_x got %h exp 0", spr_x[9:0]); end
    bus_read(8'h81, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL pending_set got %h exp 1", d); end
    checks++; if (spr_x[9:0] !== 10'h0) begin errors++; $display("FAIL mid_frame_x got %h exp 0", spr_x[9:0]); end
    frame_edge();
    checks++; if (spr_x[9:0] !== 10'h032) begin errors++; $display("FAIL commit_x got %h exp 032", spr_x[9:0]); end
    checks++; if (spr_y[9:0] !== 10'h064) begin errors++; $display("FAIL commit_y got %h exp 064", spr_y[9:0]); end
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL pulse_hi got %b exp 1", commit_pulse); end
    @(negedge clk);
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL pulse_one_cycle got %b exp 0", commit_pulse); end
    bus_read(8'h81, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL pending_clr got %h exp 0", d); end
  endtask

  task automatic test_manual_commit();
    logic [31:0] d;
    bus_write(8'h80, 32'h0);
    bus_write(8'h07, 32'h8000_0005);
    for (int i = 0; i < 2; i++) begin
      frame_edge();
      checks++; if ({spr_en[3], spr_frame[15:12]} !== 5'h0) begin errors++; $display("FAIL manual_hold%0d got %h exp 0", i, {spr_en[3], spr_frame[15:12]}); end
    end
    bus_write(8'h80, 32'h2);
    bus_read(8'h81, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL manual_status_pre got %h exp 3", d); end
    frame_edge();
    checks++; if (spr_en !== 8'h08) begin errors++; $display("FAIL manual_en got %h exp 08", spr_en); end
    checks++; if (spr_frame[15:12] !== 4'h5) begin errors++; $display("FAIL manual_frame got %h exp 5", spr_frame[15:12]); end
    bus_read(8'h81, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL manual_status_post got %h exp 0", d); end
    bus_read(8'h82, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL manual_fcnt got %h exp 4", d); end
    bus_write(8'h80, 32'h1);
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_write(8'h00, 32'h000A_0014);
    @(negedge clk);
    bus.avs_address = 8'h00; bus.avs_writedata = 32'h0033_0044;
    bus.avs_write = 1'b1; frame_sync = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0; frame_sync = 1'b0;
    checks++; if ({spr_y[9:0], spr_x[9:0]} !== {10'h00A, 10'h014}) begin errors++; $display("FAIL collide_old got %h exp %h", {spr_y[9:0], spr_x[9:0]}, {10'h00A, 10'h014}); end
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL collide_pulse got %b exp 1", commit_pulse); end
    bus_read(8'h81, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL collide_pending got %h exp 1", d); end
    frame_edge();
    checks++; if ({spr_y[9:0], spr_x[9:0]} !== {10'h033, 10'h044}) begin errors++; $display("FAIL collide_new got %h exp %h", {spr_y[9:0], spr_x[9:0]}, {10'h033, 10'h044}); end
    bus_read(8'h82, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL collide_fcnt got %h exp 6", d); end
  endtask

  task automatic test_read_write_same();
    logic [31:0] d;
    @(negedge clk);
    bus.avs_address = 8'h80; bus.avs_writedata = 32'h0;
    bus.avs_write = 1'b1; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0; bus.avs_read = 1'b0;
    checks++; if (bus.avs_readdata !== 32'h1) begin errors++; $display("FAIL rw_prewrite got %h exp 1", bus.avs_readdata); end
    repeat (2) @(negedge clk);
    checks++; if (bus.avs_readdata !== 32'h1) begin errors++; $display("FAIL rdata_hold got %h exp 1", bus.avs_readdata); end
    bus_read(8'h80, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rw_postwrite got %h exp 0", d); end
    bus_write(8'h80, 32'h1);
  endtask

  task automatic test_readback();
    logic [31:0] d;
    bus_write(8'h01, 32'h8000_0007);
    bus_read(8'h01, d);
`ifdef SPRITE_PARAMS_READBACK_EN
    checks++; if (d !== 32'h8000_0007) begin errors++; $display("FAIL readback_attr got %h exp 80000007", d); end
`else
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL readback_attr got %h exp 0", d); end
`endif
    bus_read(8'h7F, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_7f got %h exp 0", d); end
    bus_write(8'h81, 32'hFFFF_FFFF);
    bus_write(8'h82, 32'hFFFF_FFFF);
    bus_read(8'h81, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL status_ro got %h exp 1", d); end
    bus_read(8'h82, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL fcnt_ro got %h exp 6", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(negedge clk);
    reset = 1'b1; frame_sync = 1'b1;
    bus.avs_address = 8'h80; bus.avs_read = 1'b1;
    @(negedge clk);
    reset = 1'b0; frame_sync = 1'b0; bus.avs_read = 1'b0;
    checks++; if (bus.avs_readdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", bus.avs_readdata); end
    checks++; if ({spr_x, spr_y, spr_frame, spr_en} !== '0) begin errors++; $display("FAIL rstmid_spr got nonzero exp 0"); end
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL rstmid_pulse0 got %b exp 0", commit_pulse); end
    @(negedge clk);
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL rstmid_pulse1 got %b exp 0", commit_pulse); end
    bus_read(8'h80, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rstmid_ctrl got %h exp 1", d); end
    bus_read(8'h81, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_status got %h exp 0", d); end
    bus_read(8'h82, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_fcnt got %h exp 0", d); end
  endtask

  task automatic test_frame_wrap();
    logic [31:0] d;
    for (int i = 0; i < 65535; i++) frame_edge();
    bus_read(8'h82, d);
    checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL fcnt_max got %h exp ffff", d); end
    frame_edge();
    frame_edge();
    bus_read(8'h82, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL fcnt_wrap got %h exp 1", d); end
    checks++; if (spr_x !== '0) begin errors++; $display("FAIL wrap_no_commit got %h exp 0", spr_x); end
  endtask

  initial begin
    bus.avs_address = '0; bus.avs_read = 1'b0;
    bus.avs_write = 1'b0; bus.avs_writedata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_commit_edge();
    test_manual_commit();
    test_collision();
    test_read_write_same();
    test_readback();
    test_reset_mid();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_param_regs.md
SPRITE_PARAM_REGS -- requirements
Module: sprite_param_regs

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 8: number of sprites; legal range 1..8.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port avs_address, input, 8: Avalon-MM slave word address.
REQ-005 SHALL have port avs_read, input, 1: read strobe.
REQ-006 SHALL have port avs_write, input, 1: write strobe.
REQ-007 SHALL have port avs_writedata, input, 32: write data.
REQ-008 SHALL have port avs_readdata, output, 32: read data, registered.
REQ-009 SHALL have port frame_sync, input, 1: video frame sync; a rising edge marks the frame boundary.
REQ-010 SHALL have port spr_x, output, NUM_SPRITES*10: active X positions; sprite k occupies bits [10k+9:10k].
REQ-011 SHALL have port spr_y, output, NUM_SPRITES*10: active Y positions, packed the same way as spr_x.
REQ-012 SHALL have port spr_frame, output, NUM_SPRITES*4: active animation frame index per sprite.
REQ-013 SHALL have port spr_en, output, NUM_SPRITES: active visible flag per sprite.
REQ-014 SHALL have port commit_pulse, output, 1: one-cycle strobe when the active set is updated.

Function
REQ-015 SHALL decode the address map as follows:
- Address 2k (k < NUM_SPRITES): POS word, x in [9:0], y in [25:16].
- Address 2k+1: ATTR word, frame in [3:0], en in [31].
- 0x80 CTRL: bit0 auto_commit (R/W); bit1 commit_req (write 1 to set, reads current flag).
- 0x81 STATUS (read-only): bit0 pending, bit1 commit_req.
- 0x82 FRAME_COUNT (read-only): 16-bit count in [15:0].
REQ-016 SHALL ignore writes to unmapped or read-only addresses and SHALL return 0 for reads of unmapped addresses.
REQ-017 SHALL apply sprite writes to the shadow set only, in the cycle after the write strobe, and SHALL set pending.
REQ-018 SHALL register avs_readdata with a fixed read latency of 1 cycle, with no waitrequest, and SHALL hold its value between reads.
REQ-019 SHALL make a read that coincides with a write to the same address return the pre-write value.
REQ-020 SHALL detect the frame edge as frame_sync=1 while the previous cycle's sample of frame_sync was 0.
REQ-021 SHALL commit on a frame edge when (auto_commit AND pending) OR commit_req:
- copy the whole shadow set to the active set in one cycle;
- clear pending and commit_req;
- assert commit_pulse in the following cycle only.
REQ-022 SHALL, when a sprite write and a committing frame edge fall in the same cycle, commit the pre-write shadow contents, apply the write to shadow, and leave pending=1.
REQ-023 SHALL, when a commit_req write and a frame edge fall in the same cycle, commit on that edge if the commit condition held before the write; otherwise commit_req SHALL stay set for the next edge.
REQ-024 SHALL increment FRAME_COUNT on every frame edge, whether or not a commit occurs, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL change the active outputs only on a commit; shadow writes SHALL never appear mid-frame.

Reset
REQ-026 SHALL, on reset, clear:
- the shadow and active sets;
- spr_x, spr_y, spr_frame and spr_en;
- pending, commit_req and FRAME_COUNT;
- avs_readdata and commit_pulse;
- the frame_sync history register.
REQ-027 SHALL set auto_commit to 1 on reset.
REQ-028 SHALL let reset asserted mid-operation override any simultaneous write, read or frame edge; no commit_pulse SHALL follow.

Configuration
REQ-029 SHALL, with SPRITE_PARAMS_READBACK_EN defined, return shadow POS/ATTR contents on reads of sprite addresses.
REQ-030 SHALL, without SPRITE_PARAMS_READBACK_EN, return 0 for sprite-address reads; CTRL, STATUS and FRAME_COUNT remain readable and all write and commit behaviour is unchanged.

Verification
REQ-031 SHALL cover commit on frame edge: write 0x0064_0032 to address 0 -> spr_x[9:0] stays 0 until a frame_sync edge, then becomes 0x032 with spr_y[9:0]=0x064, and commit_pulse is high for exactly 1 cycle.
REQ-032 SHALL cover manual commit: with auto_commit=0, write sprite 3 ATTR 0x8000_0005 -> no change across 2 edges; write CTRL=0x2 -> next edge gives spr_en[3]=1 and spr_frame[15:12]=5, and STATUS reads 0.
REQ-033 SHALL cover write/edge collision: sprite 0 POS write coincident with an edge -> the old shadow value is committed and STATUS.pending reads 1 afterwards.
REQ-034 SHALL cover frame counter wrap: 65537 frame edges after reset -> FRAME_COUNT reads 0x0001.
REQ-035 SHALL cover reset mid-operation: reset asserted during a read and an edge -> avs_readdata=0, all spr_* = 0, CTRL reads 0x1, and no commit_pulse.
REQ-036 SHALL cover readback macro: read of address 1 after writing 0x8000_0007 -> 0x8000_0007 with SPRITE_PARAMS_READBACK_EN defined, 0x0000_0000 without; read of 0x7F -> 0.
